// File: rtl/ray_dispatch.sv
// Frame ray issue stage: walks the screen, issues one primary ray per pixel, counts retirements.
// Optional build macro RAY_DISPATCH_INTERLACE_EN selects even-rows-then-odd-rows issue order.
package ray_dispatch_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  sample_id;
        logic [7:0]  flags;
    } RasterInputData;
endpackage

module ray_dispatch
    import ray_dispatch_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120,
    parameter int unsigned X_W           = $clog2(SCREEN_WIDTH),
    parameter int unsigned Y_W           = $clog2(SCREEN_HEIGHT),
    parameter int unsigned CNT_W         = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           fifo_full,
    input  logic           retire,
    output logic           add_input,
    output RasterInputData input_data,
    output logic           busy,
    output logic           frame_done,
    output logic [7:0]     frame_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(SCREEN_WIDTH*SCREEN_HEIGHT);
    localparam logic [X_W-1:0]   X_LAST = X_W'(SCREEN_WIDTH-1);
`ifdef RAY_DISPATCH_INTERLACE_EN
    // The final row issued is the last odd row.
    localparam logic [Y_W-1:0]   Y_LAST = (SCREEN_HEIGHT % 2 == 0) ? Y_W'(SCREEN_HEIGHT-1)
                                                                   : Y_W'(SCREEN_HEIGHT-2);
`else
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(SCREEN_HEIGHT-1);
`endif

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [7:0]         frame_id_q, frame_id_d;
    logic [Y_W-1:0]     y_next;
    logic               issue;

`ifdef RAY_DISPATCH_INTERLACE_EN
    logic [Y_W:0]       y_plus2;

    always_comb begin
        y_plus2 = {1'b0, y_q} + (Y_W+1)'(2);
        if (!y_q[0] && (y_plus2 >= (Y_W+1)'(SCREEN_HEIGHT))) begin
            y_next = Y_W'(1);
        end else begin
            y_next = y_plus2[Y_W-1:0];
        end
    end
`else
    always_comb begin
        y_next = y_q + Y_W'(1);
    end
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        frame_id_d = frame_id_q;
        issue      = (state_q == ISSUE) && !fifo_full;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d       = '0;
                    y_d       = '0;
                    issued_d  = '0;
                    retired_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    issued_d = issued_q + CNT_W'(1);
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = DRAIN;
                    end else if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_next;
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((retired_q == TOTAL) && (issued_q == TOTAL)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_id_d = frame_id_q + 8'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Retirements count alongside issues, saturating at a full frame.
        if (((state_q == ISSUE) || (state_q == DRAIN)) && retire && (retired_q != TOTAL)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            frame_id_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            frame_id_q <= frame_id_d;
        end
    end

    always_comb begin
        input_data   = '0;
        input_data.x = 16'(x_q);
        input_data.y = 16'(y_q);
    end

    assign add_input  = issue;
    assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign frame_done = (state_q == DONE);
    assign frame_id   = frame_id_q;

endmodule

// File: tb/tb_ray_dispatch.sv
// Self-checking bench for ray_dispatch: scenario table on a 4x2 screen plus reset and 4x4 order sequences.
module tb_ray_dispatch;
    import ray_dispatch_pkg::*;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } pix_t;

    typedef struct {
        int stall_at;
        int stall_len;
        bit retire_with_issue;
        bit spam;
        int exp_frame_id;
        int exp_done_lat;
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic           start_a = 0, fifo_full_a = 0, retire_a = 0;
    logic           add_a, busy_a, done_a;
    RasterInputData data_a;
    logic [7:0]     frame_id_a;

    logic           start_b = 0, fifo_full_b = 0, retire_b = 0;
    logic           add_b, busy_b, done_b;
    RasterInputData data_b;
    logic [7:0]     frame_id_b;

    pix_t qa[$];
    pix_t qb[$];
    int   n_issued_a = 0, n_issued_b = 0;
    int   done_cnt_a = 0, done_cnt_b = 0;
    int   done_cyc_a = 0;

    ray_dispatch #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .fifo_full(fifo_full_a), .retire(retire_a),
        .add_input(add_a), .input_data(data_a), .busy(busy_a), .frame_done(done_a),
        .frame_id(frame_id_a)
    );

    ray_dispatch #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(4)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .fifo_full(fifo_full_b), .retire(retire_b),
        .add_input(add_b), .input_data(data_b), .busy(busy_b), .frame_done(done_b),
        .frame_id(frame_id_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_full_a) begin
                checks++;
                if (add_a) begin
                    failures++;
                    $display("FAIL stall_issue actual=1 expected=0 cyc=%0d", cyc);
                end
            end
            if (add_a) begin
                pix_t e;
                n_issued_a++;
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL extra_issue_a actual=(%0d,%0d) expected=none", data_a.x, data_a.y);
                end else begin
                    e = qa.pop_front();
                    if ((data_a.x != e.x) || (data_a.y != e.y)) begin
                        failures++;
                        $display("FAIL pixel_a actual=(%0d,%0d) expected=(%0d,%0d)",
                                 data_a.x, data_a.y, e.x, e.y);
                    end
                end
                checks++;
                if ((data_a.sample_id != 8'd0) || (data_a.flags != 8'd0)) begin
                    failures++;
                    $display("FAIL unused_fields actual=%0h/%0h expected=0/0", data_a.sample_id, data_a.flags);
                end
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (add_b) begin
                pix_t e;
                n_issued_b++;
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_issue_b actual=(%0d,%0d) expected=none", data_b.x, data_b.y);
                end else begin
                    e = qb.pop_front();
                    if ((data_b.x != e.x) || (data_b.y != e.y)) begin
                        failures++;
                        $display("FAIL pixel_b actual=(%0d,%0d) expected=(%0d,%0d)",
                                 data_b.x, data_b.y, e.x, e.y);
                    end
                end
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_int({tag, "_add_input"}, int'(add_a), 0);
        check_int({tag, "_busy"}, int'(busy_a), 0);
        check_int({tag, "_frame_done"}, int'(done_a), 0);
        check_int({tag, "_frame_id"}, int'(frame_id_a), 0);
        check_int({tag, "_x"}, int'(data_a.x), 0);
        check_int({tag, "_y"}, int'(data_a.y), 0);
    endtask

    task automatic push_frame_a();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                qa.push_back('{x: 16'(x), y: 16'(y)});
    endtask

    task automatic run_frame(input scen_t s);
        int stall_left, ret_sent, last_ret, done0, budget;
        bit spam1, spam2;
        done0 = done_cnt_a;
        n_issued_a = 0;
        stall_left = s.stall_len;
        ret_sent = 0;
        last_ret = -100;
        spam1 = 0;
        spam2 = 0;
        budget = 0;
        push_frame_a();
        start_a = 1;
        tick();
        start_a = 0;
        check_int("busy_after_start", int'(busy_a), 1);
        while ((done_cnt_a == done0) && (budget < 200)) begin
            fifo_full_a = (n_issued_a == s.stall_at) && (stall_left > 0);
            if (fifo_full_a) stall_left--;
            if (s.retire_with_issue) retire_a = !fifo_full_a && (n_issued_a < 8) && (ret_sent < 8);
            else                     retire_a = (n_issued_a == 8) && (ret_sent < 8);
            start_a = 0;
            if (s.spam && (n_issued_a == 3) && !spam1) begin start_a = 1; spam1 = 1; end
            if (s.spam && (n_issued_a == 8) && !spam2) begin start_a = 1; spam2 = 1; end
            if (retire_a) begin ret_sent++; last_ret = cyc; end
            tick();
            budget++;
        end
        fifo_full_a = 0;
        retire_a = 0;
        start_a = 0;
        check_int("frame_done_seen", done_cnt_a - done0, 1);
        check_int("done_latency", done_cyc_a - last_ret, s.exp_done_lat);
        repeat (4) tick();
        check_int("single_done", done_cnt_a - done0, 1);
        check_int("frame_id", int'(frame_id_a), s.exp_frame_id);
        check_int("busy_idle", int'(busy_a), 0);
        check_int("queue_empty", qa.size(), 0);
        check_int("issued_count", n_issued_a, 8);
    endtask

    scen_t table_v[5];
    int    rows[4];

    initial begin
        int budget;
        scen_t s;

        table_v[0] = '{stall_at: -1, stall_len: 0, retire_with_issue: 0, spam: 0, exp_frame_id: 1, exp_done_lat: 2};
        table_v[1] = '{stall_at:  2, stall_len: 3, retire_with_issue: 0, spam: 0, exp_frame_id: 2, exp_done_lat: 2};
        table_v[2] = '{stall_at: -1, stall_len: 0, retire_with_issue: 1, spam: 0, exp_frame_id: 3, exp_done_lat: 2};
        table_v[3] = '{stall_at:  5, stall_len: 2, retire_with_issue: 1, spam: 0, exp_frame_id: 4, exp_done_lat: 2};
        table_v[4] = '{stall_at: -1, stall_len: 0, retire_with_issue: 0, spam: 1, exp_frame_id: 5, exp_done_lat: 2};

        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 0;
        tick();
        check_idle_outputs("idle");

        for (int i = 0; i < 5; i++) run_frame(table_v[i]);

        // Reset in the middle of a frame.
        n_issued_a = 0;
        push_frame_a();
        start_a = 1;
        tick();
        start_a = 0;
        budget = 0;
        while ((n_issued_a < 5) && (budget < 50)) begin
            tick();
            budget++;
        end
        check_int("five_issued", n_issued_a, 5);
        rst = 1;
        #1;
        check_idle_outputs("midreset");
        qa.delete();
        tick();
        tick();
        rst = 0;
        budget = done_cnt_a;
        for (int i = 0; i < 3; i++) begin
            retire_a = 1;
            tick();
            check_int("late_retire_busy", int'(busy_a), 0);
        end
        retire_a = 0;
        tick();
        check_int("late_retire_no_done", done_cnt_a - budget, 0);
        s = table_v[0];
        s.exp_frame_id = 1;
        run_frame(s);

        // 4x4 screen: row order depends on the interlace build.
`ifdef RAY_DISPATCH_INTERLACE_EN
        rows = '{0, 2, 1, 3};
`else
        rows = '{0, 1, 2, 3};
`endif
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < 4; x++)
                qb.push_back('{x: 16'(x), y: 16'(rows[r])});
        n_issued_b = 0;
        start_b = 1;
        tick();
        start_b = 0;
        budget = 0;
        while ((n_issued_b < 16) && (budget < 100)) begin
            tick();
            budget++;
        end
        check_int("b_issued", n_issued_b, 16);
        check_int("b_queue_empty", qb.size(), 0);
        retire_b = 1;
        repeat (16) tick();
        retire_b = 0;
        budget = 0;
        while ((done_cnt_b == 0) && (budget < 20)) begin
            tick();
            budget++;
        end
        tick();
        check_int("b_frame_done", done_cnt_b, 1);
        check_int("b_frame_id", int'(frame_id_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ray_dispatch.md
# ray_dispatch

Frame-level ray issue stage directly upstream of the ray core. On a start pulse it walks every pixel of the screen in raster order and issues one primary-ray request per pixel into the ray core's raster input FIFO, respecting that FIFO's full flag. It then counts shaded pixels coming back from the ray core and signals frame completion once every issued pixel has retired.

## Interface
- `SCREEN_WIDTH`, default 160: pixels per row, at least 2.
- `SCREEN_HEIGHT`, default 120: rows per frame, at least 2.
- `X_W`, default `$clog2(SCREEN_WIDTH)`: x coordinate width.
- `Y_W`, default `$clog2(SCREEN_HEIGHT)`: y coordinate width.
- `CNT_W`, default `$clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1)`: issued and retired counter width.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle frame start request.
- `fifo_full`  in  1  ray core input FIFO full. While it is low, at least one entry is free.
- `retire`  in  1  ray core `valid`, i.e. one shaded pixel written out.
- `add_input`  out  1  issue strobe to the ray core.
- `input_data`  out  RasterInputData  ray request. Fields `x` and `y` hold the pixel; every other field is 0.
- `busy`  out  1  high from frame accept until `frame_done`.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `frame_id`  out  8  count of completed frames; wraps from 255 to 0.

## Operation
- State machine with states IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start` clears `cur_x`, `cur_y`, `issued` and `retired`, then moves to ISSUE.
  - Without `start`, stays in IDLE.
- **ISSUE**
  - Each cycle with `fifo_full`=0 issues the current pixel.
  - After each issue, x increments. On `x==SCREEN_WIDTH-1` x returns to 0 and y increments.
  - Issuing the pixel `(W-1,H-1)` moves the block to DRAIN.
  - With `fifo_full`=1: no issue, coordinates hold.
- **DRAIN**
  - Waits until `retired==SCREEN_WIDTH*SCREEN_HEIGHT`, then moves to DONE.
- **DONE**
  - Lasts one cycle: `frame_done`=1, `frame_id` increments, next state IDLE.
- `retire` increments `retired` in ISSUE and DRAIN, including the cycle an issue also happens. Both counters update in the same cycle.
  - `retire` in IDLE or DONE is ignored.
  - `retired` saturates at `SCREEN_WIDTH*SCREEN_HEIGHT`.
- `start` outside IDLE is ignored; it is not queued.
- `busy` = (state is ISSUE or DRAIN).
- All comparisons are unsigned.

## Timing
- `add_input` = (state==ISSUE) & !`fifo_full`. It is combinational from registered state and the input flag, so there is zero-cycle response to `fifo_full`.
- `input_data` is driven from registered `cur_x`/`cur_y`. It is stable while `add_input` is low and changes only on the edge after an issue.
- **Latency**
  - `start` at edge N: first `add_input` possible in cycle N+1.
  - Minimum frame: W·H issue cycles, plus drain, plus 1 DONE cycle.
  - `frame_done` occurs one cycle after the final retire is registered.
- **Reset**
  - All state returns to IDLE.
  - `add_input`, `busy`, `frame_done` = 0; `frame_id` = 0; coordinates and counters = 0.
  - Reset mid-frame abandons the frame with no `frame_done`. Later `retire` pulses are ignored because the block is in IDLE.

## Configuration
- `RAY_DISPATCH_INTERLACE_EN`
  - Defined: ISSUE walks even rows (0,2,4…) first, then odd rows (1,3,…). Within each row the order is still x ascending. DRAIN is entered after the last pixel of the last odd row.
  - Undefined: plain raster order, y = 0…H-1.
  - Counters, DRAIN and DONE behave identically in both builds.

## Test plan
- W=4, H=2, `fifo_full`=0, `start` pulse:
  - Requires 8 consecutive `add_input` cycles with (x,y) = (0,0)…(3,0),(0,1)…(3,1).
  - Then 8 `retire` pulses give `frame_done` 1 cycle after the 8th, and `frame_id`=1.
- W=4, H=2, `fifo_full` held high for 3 cycles after issue #2:
  - No `add_input` during those cycles.
  - Issue #3 resumes with (2,0); no duplicate and no skipped pixel.
- `retire` coinciding with `add_input` on every cycle:
  - `issued` and `retired` both advance.
  - `frame_done` arrives 1 cycle after the final retire.
- `start` pulsed in ISSUE and in DRAIN:
  - Ignored; coordinates are not reset and exactly one `frame_done` occurs.
- `reset` asserted after 5 issues:
  - Outputs go to 0 and the block returns to IDLE.
  - 3 late `retire` pulses are ignored.
  - A new `start` produces a full 8-pixel frame with `frame_id` going from 0 to 1.
- With `RAY_DISPATCH_INTERLACE_EN`, W=4, H=4:
  - Row order of issues is 0,2,1,3.
